window_dma_engine: RTL and testbench

Memory-side responder for the CNN controller's DMA command handshake. Accepts one command per start/finish handshake and services it against the single-port feature/weight RAM: gathers a 5x5 window, writes one result word, or streams filters and biases into the filter buffer. Sits between the CNN controller (initiator), the word-wide RAM and the 5x5 filter buffer.

---
 rtl/window_dma_engine.sv | 219 +++++++++++++++++++++
 tb/tb_window_dma_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_dma_engine.sv
// window_dma_engine: memory-side responder for the CNN controller's DMA
// start/finish handshake. One command per handshake: gather a KxK window,
// write one word, or stream filters/biases from RAM into the filter buffer.
// RAM outputs are registered; read data returns two edges after the edge
// that drives the address, and one access is issued every cycle.
module window_dma_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int K      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  finish,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [ADDR_W-1:0]     cmd_offset,
    input  logic [15:0]           cmd_count,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  fb_write,
    output logic                  fb_sel,
    output logic [15:0]           fb_index,
    output logic [K*K*DATA_W-1:0] fb_filter,
    output logic [DATA_W-1:0]     fb_bias
);

    localparam int KK = K * K;
    localparam int EW = $clog2(KK);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = 16 + EW;   // wide enough for cmd_count * KK reads

    localparam logic [1:0] M_READ  = 2'd0;
    localparam logic [1:0] M_WRITE = 2'd1;
    localparam logic [1:0] M_FILT  = 2'd2;
    localparam logic [1:0] M_BIAS  = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    // command registered at acceptance
    logic [1:0]        mode;
    logic [ADDR_W-1:0] offset;
    logic [15:0]       count;
    logic [TW-1:0]     total;

    // issue side
    logic [TW-1:0]     issued;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] row_base;

    // capture side
    logic              rd_pend;   // read data on mem_rdata this cycle
    logic              tail;      // command finished; go DONE on next edge
    logic [EW-1:0]     elem;
    logic [15:0]       idx;

    logic [KK-1:0][DATA_W-1:0] win_q, filt_buf, filt_q;

    logic          accept, capture, issue, last_elem, last_idx;
    logic [TW-1:0] total_new;

    assign win_data  = win_q;
    assign fb_filter = filt_q;

    // total reads implied by the command being presented
    always_comb begin
        total_new = '0;
        case (cmd_mode)
            M_READ:  total_new = TW'(KK);
            M_FILT:  total_new = TW'(cmd_count) * TW'(KK);
            M_BIAS:  total_new = TW'(cmd_count);
            default: total_new = '0;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (tail || (capture && mode == M_READ && last_elem)) state_nxt = DONE;
            DONE: if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM-decoded controls
    always_comb begin
        accept    = (state == IDLE) && start;
        capture   = (state == RUN) && rd_pend;
        issue     = (state == RUN) && (mode != M_WRITE) && (issued != total);
        last_elem = (elem == EW'(KK - 1));
        last_idx  = (idx == count - 16'd1);
        finish    = (state == DONE);
    end

    // datapath: command capture, address generation, read capture, fb strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode      <= '0;
            offset    <= '0;
            count     <= '0;
            total     <= '0;
            issued    <= '0;
            col       <= '0;
            row_base  <= '0;
            rd_pend   <= 1'b0;
            tail      <= 1'b0;
            elem      <= '0;
            idx       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fb_write  <= 1'b0;
            fb_sel    <= 1'b0;
            fb_index  <= '0;
            fb_bias   <= '0;
            win_q     <= '0;
            filt_buf  <= '0;
            filt_q    <= '0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            fb_write <= 1'b0;
            tail     <= 1'b0;
            rd_pend  <= mem_en & ~mem_we;

            if (accept) begin
                mode     <= cmd_mode;
                offset   <= cmd_offset;
                count    <= cmd_count;
                total    <= total_new;
                mem_addr <= cmd_addr;
                row_base <= cmd_addr;
                col      <= '0;
                elem     <= '0;
                idx      <= '0;
                issued   <= '0;
                if (cmd_mode == M_WRITE) begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= cmd_wdata;
                    tail      <= 1'b1;
                end else if (total_new == '0) begin
                    tail <= 1'b1;
                end else begin
                    mem_en <= 1'b1;
                    issued <= TW'(1);
                end
            end

            if (issue) begin
                mem_en <= 1'b1;
                issued <= issued + TW'(1);
                if (mode == M_READ) begin
                    // row base advances by the stride; no multiplier needed
                    if (col == CW'(K - 1)) begin
                        row_base <= row_base + offset;
                        mem_addr <= row_base + offset;
                        col      <= '0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        col      <= col + CW'(1);
                    end
                end else begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
            end

            if (capture) begin
                case (mode)
                    M_READ: begin
                        win_q[elem] <= mem_rdata;
                        elem        <= last_elem ? '0 : elem + EW'(1);
                    end
                    M_FILT: begin
                        filt_buf[elem] <= mem_rdata;
                        if (last_elem) begin
                            // publish the filter including the word arriving now
                            for (int i = 0; i < KK - 1; i++) filt_q[i] <= filt_buf[i];
                            filt_q[KK-1] <= mem_rdata;
                            fb_write     <= 1'b1;
                            fb_sel       <= 1'b0;
                            fb_index     <= idx;
                            elem         <= '0;
                            idx          <= idx + 16'd1;
                            if (last_idx) tail <= 1'b1;
                        end else begin
                            elem <= elem + EW'(1);
                        end
                    end
                    M_BIAS: begin
                        fb_write <= 1'b1;
                        fb_sel   <= 1'b1;
                        fb_index <= idx;
                        fb_bias  <= mem_rdata;
                        idx      <= idx + 16'd1;
                        if (last_idx) tail <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_dma_engine.sv
// tb_window_dma_engine: directed table of DMA commands against a RAM model
// whose unwritten locations read back their own address, plus hand-written
// sequences for mid-command reset and start dropped during RUN.
module tb_window_dma_engine;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int K  = 5;
    localparam int KK = K * K;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              finish;
    logic [1:0]        cmd_mode;
    logic [AW-1:0]     cmd_addr;
    logic [AW-1:0]     cmd_offset;
    logic [15:0]       cmd_count;
    logic [DW-1:0]     cmd_wdata;
    logic [KK*DW-1:0]  win_data;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              fb_write;
    logic              fb_sel;
    logic [15:0]       fb_index;
    logic [KK*DW-1:0]  fb_filter;
    logic [DW-1:0]     fb_bias;

    window_dma_engine #(.DATA_W(DW), .ADDR_W(AW), .K(K)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .cmd_mode(cmd_mode), .cmd_addr(cmd_addr), .cmd_offset(cmd_offset),
        .cmd_count(cmd_count), .cmd_wdata(cmd_wdata), .win_data(win_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fb_write(fb_write),
        .fb_sel(fb_sel), .fb_index(fb_index), .fb_filter(fb_filter),
        .fb_bias(fb_bias)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: unwritten word a reads as a
    bit          ram_v [0:65535];
    logic [15:0] ram_w [0:65535];

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return ram_v[a] ? ram_w[a] : a;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram_w[mem_addr] <= mem_wdata;
                ram_v[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= model_rd(mem_addr);
            end
        end
    end

    // bus monitor
    int          acc_cyc[$];
    logic [15:0] acc_addr[$];
    bit          acc_we[$];
    logic [15:0] acc_wd[$];
    int          fb_cyc[$];
    logic [15:0] fb_idx_q[$];
    bit          fb_sel_q[$];
    logic [15:0] fb_val_q[$];
    int          bad_we = 0;
    int          bad_done = 0;

    always @(negedge clk) begin
        if (mem_en) begin
            acc_cyc.push_back(cyc);
            acc_addr.push_back(mem_addr);
            acc_we.push_back(mem_we);
            acc_wd.push_back(mem_wdata);
        end
        if (mem_we && !mem_en) bad_we++;
        if (mem_en && finish) bad_done++;
        if (fb_write) begin
            fb_cyc.push_back(cyc);
            fb_idx_q.push_back(fb_index);
            fb_sel_q.push_back(fb_sel);
            fb_val_q.push_back(fb_sel ? fb_bias : fb_filter[DW-1:0]);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] addr, off, cnt, wdata;
        int          hold, drop, lat, acc, fbw, chk, el;
        logic [15:0] val;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic [15:0] a, o, n, w,
                                input int hold, drop, lat, acc, fbw, chk, el,
                                input logic [15:0] val);
        vec_t v;
        v.mode = m; v.addr = a; v.off = o; v.cnt = n; v.wdata = w;
        v.hold = hold; v.drop = drop; v.lat = lat; v.acc = acc; v.fbw = fbw;
        v.chk = chk; v.el = el; v.val = val;
        return v;
    endfunction

    task automatic clear_logs();
        acc_cyc.delete(); acc_addr.delete(); acc_we.delete(); acc_wd.delete();
        fb_cyc.delete(); fb_idx_q.delete(); fb_sel_q.delete(); fb_val_q.delete();
    endtask

    task automatic run_cmd(input vec_t v, input int id);
        int e0, fin, bad, ec;
        logic [15:0] ea, ev;
        string p;
        p = $sformatf("v%0d", id);
        @(negedge clk);
        cmd_mode = v.mode; cmd_addr = v.addr; cmd_offset = v.off;
        cmd_count = v.cnt; cmd_wdata = v.wdata; start = 1'b1;
        clear_logs();
        e0  = cyc + 1;
        fin = -1;
        for (int i = 0; i < 3000 && fin < 0; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // command was registered at acceptance; later input changes must not matter
                cmd_mode = ~v.mode; cmd_addr = ~v.addr; cmd_offset = v.off + 16'd3;
                cmd_count = v.cnt + 16'd1; cmd_wdata = ~v.wdata;
            end
            if (finish) fin = cyc;
            else if (v.drop >= 0 && cyc - e0 == v.drop) start = 1'b0;
        end
        check({p, "_lat"}, fin - e0, v.lat);
        bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (finish !== 1'b1) bad++;
        end
        if (v.hold > 0) check({p, "_hold"}, bad, 0);
        start = 1'b0;
        @(negedge clk);
        check({p, "_fin_low"}, finish, 0);

        check({p, "_acc_n"}, acc_cyc.size(), v.acc);
        bad = 0;
        foreach (acc_cyc[k]) begin
            case (v.mode)
                2'd0:    ea = v.addr + 16'(k / K) * v.off + 16'(k % K);
                2'd1:    ea = v.addr;
                default: ea = v.addr + 16'(k);
            endcase
            if (acc_cyc[k] != e0 + k || acc_addr[k] !== ea || acc_we[k] != (v.mode == 2'd1) ||
                (v.mode == 2'd1 && acc_wd[k] !== v.wdata)) bad++;
        end
        check({p, "_acc_seq"}, bad, 0);

        check({p, "_fb_n"}, fb_cyc.size(), v.fbw);
        bad = 0;
        foreach (fb_cyc[n]) begin
            ec = (v.mode == 2'd2) ? e0 + KK * (n + 1) + 1 : e0 + n + 2;
            ev = (v.mode == 2'd2) ? model_rd(v.addr + 16'(KK * n)) : model_rd(v.addr + 16'(n));
            if (fb_cyc[n] != ec || fb_idx_q[n] !== 16'(n) || fb_sel_q[n] != (v.mode == 2'd3) ||
                fb_val_q[n] !== ev) bad++;
        end
        if (v.fbw > 0) check({p, "_fb_seq"}, bad, 0);

        if (v.mode == 2'd0) begin
            bad = 0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    if (win_data[DW*(K*r+c) +: DW] !== model_rd(v.addr + 16'(r) * v.off + 16'(c))) bad++;
            check({p, "_win_all"}, bad, 0);
        end
        if (v.mode == 2'd2 && v.cnt != 16'd0) begin
            bad = 0;
            for (int i = 0; i < KK; i++)
                if (fb_filter[DW*i +: DW] !== model_rd(v.addr + 16'(KK * (int'(v.cnt) - 1) + i))) bad++;
            check({p, "_filt_all"}, bad, 0);
        end

        case (v.chk)
            1: check({p, "_win_el"},  win_data[DW*v.el +: DW],  v.val);
            2: check({p, "_filt_el"}, fb_filter[DW*v.el +: DW], v.val);
            3: check({p, "_bias"},    fb_bias,                  v.val);
            4: check({p, "_ram"},     model_rd(v.addr),         v.val);
            default: ;
        endcase
    endtask

    vec_t vecs [0:6];
    int   n_fb;

    initial begin
        //             mode  addr       off    cnt   wdata     hold drop lat acc fbw chk el val
        vecs[0] = mk(2'd0, 16'd100,   16'd28, 16'd0, 16'h0000, 3, -1, 26, 25, 0, 1, 24, 16'd216);
        vecs[1] = mk(2'd1, 16'hFFFF,  16'd0,  16'd0, 16'hFFF9, 0, -1, 1,  1,  0, 4, 0,  16'hFFF9);
        vecs[2] = mk(2'd0, 16'hFFFE,  16'd1,  16'd0, 16'h0000, 0, -1, 26, 25, 0, 1, 1,  16'hFFF9);
        vecs[3] = mk(2'd2, 16'd150,   16'd0,  16'd2, 16'h0000, 0, -1, 52, 50, 2, 2, 0,  16'd175);
        vecs[4] = mk(2'd3, 16'd50550, 16'd0,  16'd6, 16'h0000, 0, -1, 8,  6,  6, 3, 0,  16'hC57B);
        vecs[5] = mk(2'd3, 16'd50550, 16'd0,  16'd0, 16'h0000, 0, -1, 1,  0,  0, 0, 0,  16'd0);
        vecs[6] = mk(2'd2, 16'd10,    16'd0,  16'd0, 16'h0000, 0, -1, 1,  0,  0, 0, 0,  16'd0);

        reset = 1'b0; start = 1'b0; cmd_mode = '0; cmd_addr = '0;
        cmd_offset = '0; cmd_count = '0; cmd_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {finish, mem_en, mem_we, fb_write, fb_sel}, 0);
        check("reset_bus", (mem_addr == 0 && mem_wdata == 0 && fb_index == 0 && fb_bias == 0 &&
                            win_data == 0 && fb_filter == 0), 1);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i], i);

        // reset after 30 reads of a two-filter load
        @(negedge clk);
        cmd_mode = 2'd2; cmd_addr = 16'd150; cmd_count = 16'd2; start = 1'b1;
        clear_logs();
        for (int i = 0; i < 200 && acc_cyc.size() < 30; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_reads", acc_cyc.size(), 30);
        check("rst_mid_fb_before", fb_cyc.size(), 1);
        reset = 1'b0; start = 1'b0;
        #1;
        check("rst_mid_ctl", {finish, mem_en, mem_we, fb_write, fb_sel}, 0);
        check("rst_mid_bus", (mem_addr == 0 && mem_wdata == 0 && fb_index == 0 && fb_bias == 0), 1);
        check("rst_mid_arr", (win_data == 0 && fb_filter == 0), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_fb = fb_cyc.size();
        check("rst_mid_fb_after", n_fb, 1);
        check("rst_mid_acc_after", acc_cyc.size(), 30);

        // fresh window read after the abort
        run_cmd(mk(2'd0, 16'd400, 16'd7, 16'd0, 16'h0, 0, -1, 26, 25, 0, 1, 24, 16'd432), 7);

        // start dropped during RUN, overlapping rows (stride 3)
        run_cmd(mk(2'd0, 16'd300, 16'd3, 16'd0, 16'h0, 0, 5, 26, 25, 0, 1, 24, 16'd316), 8);

        check("we_without_en", bad_we, 0);
        check("access_in_done", bad_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
